// File: rtl/queue_rr_arbiter.sv
// queue_rr_arbiter: burst-limited round-robin arbiter that funnels NUM_REQ
// producers into one shared tagged FIFO. It also drains the FIFO into a
// registered valid/ready output stage that carries the requester ID.
module queue_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int BURST      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           q_enq_valid,
    output logic [DATA_WIDTH+ID_WIDTH-1:0] q_enq_data,
    input  logic                           q_full,
    output logic                           q_deq_ready,
    input  logic [DATA_WIDTH+ID_WIDTH-1:0] q_deq_data,
    input  logic                           q_empty,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [ID_WIDTH-1:0]            out_id,
    input  logic                           out_ready,
    output logic                           busy,
    output logic [ID_WIDTH-1:0]            grant_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

    state_t                               state, state_nxt;
    logic [ID_WIDTH-1:0]                  rr_ptr;
    logic [ID_WIDTH-1:0]                  owner;
    logic [7:0]                           beat_cnt;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_slices;
    logic [DATA_WIDTH-1:0]                owner_data;
    logic [ID_WIDTH-1:0]                  pick;
    logic [ID_WIDTH-1:0]                  scan_idx;
    logic                                 pick_vld;
    logic                                 owner_vld;
    logic                                 xfer;
    logic                                 release_grant;

    // Increment modulo NUM_REQ; wraps explicitly for non power-of-2 counts.
    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
        if (v == ID_WIDTH'(NUM_REQ - 1))
            return '0;
        return v + ID_WIDTH'(1);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slices[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign owner_data = req_slices[owner];
    assign owner_vld  = req_valid[owner];
    assign xfer       = (state == GRANT) && owner_vld && !q_full;
    // A stalled owner (valid but FIFO full) keeps the grant; a dropped valid releases it.
    assign release_grant = (state == GRANT) &&
                           ((xfer && (beat_cnt == LAST_BEAT)) || !owner_vld);

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        scan_idx = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_vld && req_valid[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: one arbitration bubble in IDLE per grant.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld)      state_nxt = GRANT;
            GRANT:   if (release_grant) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // FSM outputs: only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready   = '0;
        if (state == GRANT)
            req_ready[owner] = !q_full;
        q_enq_valid = xfer;
        q_enq_data  = {owner, owner_data};
        busy        = (state == GRANT);
        grant_id    = owner;
    end

    // Grant bookkeeping: owner capture, beat counting, pointer rotation on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                owner    <= pick;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (release_grant)
                rr_ptr <= wrap_inc(owner);
        end
    end

    // Pop whenever the stage is empty or being drained; gated so it drops in reset.
    assign q_deq_ready = rst_n && !q_empty && (!out_valid || out_ready);

    // Output stage: load on pop, clear on handshake without refill, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (q_deq_ready) begin
            out_valid <= 1'b1;
            out_data  <= q_deq_data[DATA_WIDTH-1:0];
            out_id    <= q_deq_data[DATA_WIDTH +: ID_WIDTH];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Bench for queue_rr_arbiter: behavioural FIFO, per-requester producer queues,
// scoreboard of expected {id,data} words popped by an output monitor.
module tb_queue_rr_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 16;
    localparam int IW    = 2;
    localparam int BURST = 4;
    localparam int DEPTH = 4;
    localparam int EW    = DW + IW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              q_enq_valid;
    logic [EW-1:0]     q_enq_data;
    logic              q_full;
    logic              q_deq_ready;
    logic [EW-1:0]     q_deq_data;
    logic              q_empty;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_id;
    logic              out_ready;
    logic              busy;
    logic [IW-1:0]     grant_id;

    always #5 clk = ~clk;

    queue_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .q_enq_valid(q_enq_valid), .q_enq_data(q_enq_data), .q_full(q_full),
        .q_deq_ready(q_deq_ready), .q_deq_data(q_deq_data), .q_empty(q_empty),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
        .busy(busy), .grant_id(grant_id)
    );

    // ---------------- behavioural FIFO ----------------
    logic [EW-1:0] fmem [DEPTH];
    int            fwr, frd, fcnt;
    logic          do_enq, do_deq;

    assign q_full     = (fcnt == DEPTH);
    assign q_empty    = (fcnt == 0);
    assign q_deq_data = fmem[frd];
    assign do_enq     = q_enq_valid && !q_full;
    assign do_deq     = q_deq_ready && !q_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwr <= 0; frd <= 0; fcnt <= 0;
        end else begin
            if (do_enq) begin
                fmem[fwr] <= q_enq_data;
                fwr <= (fwr + 1) % DEPTH;
            end
            if (do_deq) frd <= (frd + 1) % DEPTH;
            fcnt <= fcnt + int'(do_enq) - int'(do_deq);
        end
    end

    // ---------------- bookkeeping ----------------
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] prod_q [NR][$];
    logic [EW-1:0] exp_q [$];
    int            grant_q [$];
    int            beats_q [$];
    int            gap_q [$];
    int            e [$];
    int            cur_beats = 0;
    int            low_cnt = 0;
    logic          busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input int got[$], input int exp[$], input int from);
        check({name, " count"}, got.size() - from, exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s[%0d]", name, i),
                  (from + i < got.size()) ? got[from + i] : -1, exp[i]);
    endtask

    task automatic load(input int r, input logic [DW-1:0] base, input int n);
        for (int j = 0; j < n; j++) prod_q[r].push_back(base + DW'(j));
    endtask

    task automatic expect_words(input int r, input logic [DW-1:0] base, input int n);
        for (int j = 0; j < n; j++) exp_q.push_back({IW'(r), base + DW'(j)});
    endtask

    function automatic int prod_left();
        int s = 0;
        for (int i = 0; i < NR; i++) s += prod_q[i].size();
        return s;
    endfunction

    task automatic clear_logs();
        grant_q.delete(); beats_q.delete(); gap_q.delete();
        cur_beats = 0; low_cnt = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) prod_q[i].delete();
        exp_q.delete();
        cycles(2);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || prod_left() != 0) && n < budget) begin
            cycles(1);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL %s drain timeout: left=%0d expected 0", name, exp_q.size());
        end
        cycles(2);
    endtask

    // ---------------- producers ----------------
    // Transfers are decided at the falling edge, inputs re-driven just after the rising edge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) void'(prod_q[i].pop_front());
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                req_valid[i]         = (prod_q[i].size() > 0);
                req_data[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    logic          hold_v = 1'b0;
    logic [EW-1:0] held;
    initial begin
        forever begin
            @(negedge clk);
            check("enq_while_full", 32'(q_enq_valid & q_full), 0);
            check("deq_while_empty", 32'(q_deq_ready & q_empty), 0);
            check("ready_onehot", 32'($countones(req_ready) > 1), 0);
            if (hold_v && out_valid)
                check("stall_stable", 32'({out_id, out_data}), 32'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_unexpected: got %0h expected none", {out_id, out_data});
                end else begin
                    check("out_word", 32'({out_id, out_data}), 32'(exp_q.pop_front()));
                end
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold_v = 1'b1;
                held   = {out_id, out_data};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // ---------------- grant logger ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (busy && q_enq_valid) cur_beats++;
            if (busy && !busy_prev) begin
                grant_q.push_back(int'(grant_id));
                gap_q.push_back(low_cnt);
                low_cnt = 0;
            end
            if (!busy && busy_prev) begin
                beats_q.push_back(cur_beats);
                cur_beats = 0;
            end
            if (!busy) low_cnt++;
            busy_prev = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst req_ready",   32'(req_ready), 0);
        check("rst q_enq_valid", 32'(q_enq_valid), 0);
        check("rst q_deq_ready", 32'(q_deq_ready), 0);
        check("rst out_valid",   32'(out_valid), 0);
        check("rst out_data",    32'(out_data), 0);
        check("rst out_id",      32'(out_id), 0);
        check("rst busy",        32'(busy), 0);
        check("rst grant_id",    32'(grant_id), 0);

        // Single requester, 6 words split 4 + 2 by the burst limit.
        do_reset();
        out_ready = 1'b1;
        load(2, 16'h0100, 6);
        expect_words(2, 16'h0100, 6);
        wait_drain("single", 200);
        e = {2, 2};    check_seq("single grants", grant_q, e, 0);
        e = {4, 2};    check_seq("single beats", beats_q, e, 0);
        e = {1};       check_seq("single gap", gap_q, e, 1);

        // Contention: all four valid, rotate 0,1,2,3,0 with 4 beats each.
        do_reset();
        load(0, 16'h1000, 8);
        load(1, 16'h2000, 4);
        load(2, 16'h3000, 4);
        load(3, 16'h4000, 4);
        expect_words(0, 16'h1000, 4);
        expect_words(1, 16'h2000, 4);
        expect_words(2, 16'h3000, 4);
        expect_words(3, 16'h4000, 4);
        expect_words(0, 16'h1004, 4);
        wait_drain("contend", 300);
        e = {0, 1, 2, 3, 0};  check_seq("contend grants", grant_q, e, 0);
        e = {4, 4, 4, 4, 4};  check_seq("contend beats", beats_q, e, 0);
        e = {1, 1, 1, 1};     check_seq("contend gaps", gap_q, e, 1);

        // Early release: req 1 runs dry after 2 beats, req 3 is next.
        do_reset();
        load(1, 16'h5100, 2);
        load(3, 16'h5300, 3);
        expect_words(1, 16'h5100, 2);
        expect_words(3, 16'h5300, 3);
        wait_drain("early", 200);
        e = {1, 3};    check_seq("early grants", grant_q, e, 0);
        e = {2, 3};    check_seq("early beats", beats_q, e, 0);
        e = {1};       check_seq("early gap", gap_q, e, 1);

        // Backpressure: FIFO fills with out_ready low, grant held, beat count frozen.
        do_reset();
        out_ready = 1'b0;
        load(0, 16'h6000, 8);
        expect_words(0, 16'h6000, 8);
        cycles(20);
        @(negedge clk);
        check("bp fifo_full",   32'(q_full), 1);
        check("bp busy",        32'(busy), 1);
        check("bp grant_id",    32'(grant_id), 0);
        check("bp req_ready",   32'(req_ready), 0);
        check("bp q_enq_valid", 32'(q_enq_valid), 0);
        check("bp out_valid",   32'(out_valid), 1);
        check("bp out_data",    32'(out_data), 32'h6000);
        check("bp words_left",  prod_left(), 3);
        cycles(1);
        out_ready = 1'b1;
        wait_drain("bp", 200);
        e = {0, 0};    check_seq("bp grants", grant_q, e, 0);
        e = {4, 4};    check_seq("bp beats", beats_q, e, 0);

        // Output stall: out_ready 1,0,0,1 with three words queued.
        do_reset();
        out_ready = 1'b0;
        load(1, 16'h7000, 3);
        expect_words(1, 16'h7000, 3);
        cycles(10);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall c0 data", 32'(out_data), 32'h7000);
        cycles(1);
        out_ready = 1'b0;
        @(negedge clk);
        check("stall c1 valid", 32'(out_valid), 1);
        check("stall c1 data",  32'(out_data), 32'h7001);
        cycles(1);
        @(negedge clk);
        check("stall c2 data",  32'(out_data), 32'h7001);
        cycles(1);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall c3 data",  32'(out_data), 32'h7001);
        cycles(1);
        wait_drain("stall", 100);
        e = {1};       check_seq("stall grants", grant_q, e, 0);
        e = {3};       check_seq("stall beats", beats_q, e, 0);

        // Reset mid-burst: state and held output vanish, pointer back to 0.
        do_reset();
        out_ready = 1'b0;
        load(2, 16'h8000, 8);
        expect_words(2, 16'h8000, 8);
        cycles(12);
        @(negedge clk);
        check("mid pre busy",      32'(busy), 1);
        check("mid pre out_valid", 32'(out_valid), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid req_ready",   32'(req_ready), 0);
        check("mid out_valid",   32'(out_valid), 0);
        check("mid q_deq_ready", 32'(q_deq_ready), 0);
        check("mid busy",        32'(busy), 0);
        for (int i = 0; i < NR; i++) prod_q[i].delete();
        exp_q.delete();
        cycles(2);
        clear_logs();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        load(3, 16'h9300, 2);
        load(1, 16'h9100, 2);
        expect_words(1, 16'h9100, 2);
        expect_words(3, 16'h9300, 2);
        wait_drain("post_rst", 200);
        e = {1, 3};    check_seq("post_rst grants", grant_q, e, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
